// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one external memory port between instruction fetch and data
// load/store. Accesses are serialised, the shared bus is steered to the
// granted requester, and each result comes back with a one-cycle done pulse.
// Build option: define MEM_ARB_TIMEOUT_EN to abort accesses whose response
// does not arrive within TIMEOUT_CYCLES; without it the block waits forever.
module mem_port_arbiter #(
   parameter int WORD_SIZE      = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,      // active-high synchronous reset
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic [WORD_SIZE-1:0] i_data,
   output logic                 i_done,
   input  logic                 d_read_req,
   input  logic                 d_write_req,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 d_done,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   input  logic                 ackOutput,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DREAD, S_DWRITE, S_DONE} state_t;

   state_t               r_state;
   logic                 r_last_data;   // 1: data class was granted last
   logic                 r_timeout_err;
   logic [CW-1:0]        r_cnt;
   logic [WORD_SIZE-1:0] r_wdata;

   logic w_data_req;
   logic w_grant_fetch;
   logic w_in_access;
   logic w_expired;
   logic w_abort;

   // Fetch wins when alone, or on a tie when data was served last.
   assign w_data_req    = d_write_req | d_read_req;
   assign w_grant_fetch = i_req & (~w_data_req | r_last_data);
   assign w_in_access   = (r_state == S_FETCH) | (r_state == S_DREAD) | (r_state == S_DWRITE);
   // Counter holds the number of response-less cycles already spent; the
   // edge at which it equals TIMEOUT_CYCLES-1 is the last chance to respond.
   assign w_expired     = TMO_EN & (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign w_abort       = w_expired &
                          (((r_state == S_FETCH) | (r_state == S_DREAD)) & ~inputReady |
                           (r_state == S_DWRITE) & ~ackOutput);

   assign busy        = (r_state != S_IDLE);
   assign data        = writeM ? r_wdata : {WORD_SIZE{1'bz}};
   assign timeout_err = r_timeout_err;

   // Wait counter: zero outside accesses, counts every cycle inside one.
   always_ff @(posedge clk) begin
      if (reset_n)          r_cnt <= '0;
      else if (w_in_access) r_cnt <= r_cnt + CW'(1);
      else                  r_cnt <= '0;
   end

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset_n)      r_timeout_err <= 1'b0;
      else if (w_abort) r_timeout_err <= 1'b1;
   end

   // Arbitration and access sequencing with registered bus/result outputs.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         r_state     <= S_IDLE;
         r_last_data <= 1'b1;
         r_wdata     <= '0;
         readM       <= 1'b0;
         writeM      <= 1'b0;
         address     <= '0;
         i_data      <= '0;
         d_rdata     <= '0;
         i_done      <= 1'b0;
         d_done      <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_fetch) begin
                  r_state     <= S_FETCH;
                  readM       <= 1'b1;
                  address     <= i_addr;
                  r_last_data <= 1'b0;
               end else if (d_write_req) begin
                  r_state     <= S_DWRITE;
                  writeM      <= 1'b1;
                  address     <= d_addr;
                  r_wdata     <= d_wdata;
                  r_last_data <= 1'b1;
               end else if (d_read_req) begin
                  r_state     <= S_DREAD;
                  readM       <= 1'b1;
                  address     <= d_addr;
                  r_last_data <= 1'b1;
               end
            end
            S_FETCH, S_DREAD: begin
               // A response in the expiry cycle still counts as a normal read.
               if (inputReady || w_expired) begin
                  readM   <= 1'b0;
                  r_state <= S_DONE;
                  if (r_state == S_FETCH) begin
                     i_done <= 1'b1;
                     i_data <= inputReady ? data : '0;
                  end else begin
                     d_done  <= 1'b1;
                     d_rdata <= inputReady ? data : '0;
                  end
               end
            end
            S_DWRITE: begin
               if (ackOutput || w_expired) begin
                  writeM  <= 1'b0;
                  d_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            // Turnaround cycle so the requester can drop its request.
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus randomized requesters/memory checked every cycle against a
// transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   localparam int TMO = 15;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        i_req = 1'b0, d_read_req = 1'b0, d_write_req = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [15:0] i_data, d_rdata, address;
   logic        i_done, d_done, readM, writeM, busy, timeout_err;
   logic        inputReady = 1'b0, ackOutput = 1'b0;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_dval = '0;
   wire  [15:0] data;

   assign data = tb_drv ? tb_dval : 16'hzzzz;

   int checks = 0, errors = 0;
   bit chk_en = 1'b0, auto_mem = 1'b0;
   int lat = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WORD_SIZE(16), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done),
      .d_read_req(d_read_req), .d_write_req(d_write_req), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
      .readM(readM), .writeM(writeM), .address(address), .data(data),
      .inputReady(inputReady), .ackOutput(ackOutput),
      .busy(busy), .timeout_err(timeout_err)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // m_phase: 0 port free, 1 access outstanding, 2 turnaround after completion
   // m_who:   0 fetch, 1 load, 2 store
   int          m_phase = 0, m_who = 0, m_wait = 0, pick;
   bit          m_last_data = 1'b1, m_idone = 1'b0, m_ddone = 1'b0, m_terr = 1'b0;
   bit          resp, dq;
   logic [15:0] m_addr = '0, m_wdata = '0, m_idata = '0, m_drdata = '0;

   always @(posedge clk) begin
      if (reset_n) begin
         m_phase = 0; m_last_data = 1'b1; m_addr = '0; m_idata = '0; m_drdata = '0;
         m_idone = 1'b0; m_ddone = 1'b0; m_terr = 1'b0;
      end else begin
         m_idone = 1'b0; m_ddone = 1'b0;
         if (m_phase == 2) m_phase = 0;
         else if (m_phase == 1) begin
            resp = (m_who == 2) ? ackOutput : inputReady;
            m_wait++;
            if (resp || (TMO_EN && m_wait == TMO)) begin
               if (!resp) m_terr = 1'b1;
               if (m_who == 0) begin m_idone = 1'b1; m_idata = resp ? data : 16'h0; end
               else begin
                  m_ddone = 1'b1;
                  if (m_who == 1) m_drdata = resp ? data : 16'h0;
               end
               m_phase = 2;
            end
         end else begin
            dq = d_read_req | d_write_req;
            pick = -1;
            if (i_req && dq) pick = m_last_data ? 0 : (d_write_req ? 2 : 1);
            else if (i_req) pick = 0;
            else if (dq)    pick = d_write_req ? 2 : 1;
            if (pick >= 0) begin
               m_who = pick; m_phase = 1; m_wait = 0;
               m_last_data = (pick != 0);
               m_addr = (pick == 0) ? i_addr : d_addr;
               if (pick == 2) m_wdata = d_wdata;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("readM",   readM,   32'(m_phase == 1 && m_who != 2));
         chk("writeM",  writeM,  32'(m_phase == 1 && m_who == 2));
         chk("busy",    busy,    32'(m_phase != 0));
         chk("address", address, m_addr);
         chk("i_done",  i_done,  m_idone);
         chk("d_done",  d_done,  m_ddone);
         chk("i_data",  i_data,  m_idata);
         chk("d_rdata", d_rdata, m_drdata);
         chk("timeout_err", timeout_err, m_terr);
         if (m_phase == 1 && m_who == 2) chk("data_bus", data, m_wdata);
      end
   end

   // Randomized memory: responds after 0..3 extra cycles, plus stray strobes.
   always @(negedge clk) begin
      if (auto_mem) begin
         inputReady = 1'b0; ackOutput = 1'b0; tb_drv = 1'b0;
         if (readM) begin
            if (lat == 0) begin
               inputReady = 1'b1; tb_drv = 1'b1; tb_dval = 16'($urandom);
               lat = $urandom_range(0, 3);
            end else begin
               lat--;
               ackOutput = ($urandom_range(0, 3) == 0);
            end
         end else if (writeM) begin
            if (lat == 0) begin ackOutput = 1'b1; lat = $urandom_range(0, 3); end
            else begin lat--; inputReady = ($urandom_range(0, 3) == 0); end
         end else begin
            inputReady = ($urandom_range(0, 5) == 0);
            ackOutput  = ($urandom_range(0, 5) == 0);
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int grants[$];
   bit prev_strobe;
   int seen;

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      // reset state
      chk("rst_readM", readM, 0);   chk("rst_writeM", writeM, 0);
      chk("rst_busy", busy, 0);     chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0); chk("rst_address", address, 0);
      chk("rst_i_data", i_data, 0); chk("rst_d_rdata", d_rdata, 0);
      chk("rst_terr", timeout_err, 0);
      reset_n = 1'b0;

      // fetch, response on the 2nd access cycle
      i_req = 1'b1; i_addr = 16'h0010;
      @(negedge clk);
      chk("f_readM0", readM, 1); chk("f_addr", address, 16'h0010); chk("f_busy", busy, 1);
      i_addr = 16'h7777;   // ignored during the access
      @(negedge clk);
      chk("f_readM1", readM, 1); chk("f_addr_hold", address, 16'h0010);
      inputReady = 1'b1; tb_drv = 1'b1; tb_dval = 16'hF01C;
      @(negedge clk);
      chk("f_done", i_done, 1); chk("f_readM_off", readM, 0); chk("f_data", i_data, 16'hF01C);
      chk("f_no_ddone", d_done, 0);
      i_req = 1'b0; inputReady = 1'b0; tb_drv = 1'b0;
      @(negedge clk);
      chk("f_done_pulse", i_done, 0); chk("f_idle", busy, 0); chk("f_data_held", i_data, 16'hF01C);

      // store, ack after 3 cycles
      d_write_req = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("s_writeM", writeM, 1); chk("s_bus", data, 16'h1234); chk("s_addr", address, 16'h0040);
         d_wdata = 16'hDEAD;
         if (k == 2) ackOutput = 1'b1;
      end
      @(negedge clk);
      chk("s_done", d_done, 1); chk("s_writeM_off", writeM, 0);
      d_write_req = 1'b0; ackOutput = 1'b0;
      @(negedge clk);
      chk("s_done_pulse", d_done, 0);

      // contention: all requests held from reset
      i_req = 1'b1; d_read_req = 1'b1; d_write_req = 1'b1;
      i_addr = 16'h0100; d_addr = 16'h0200; d_wdata = 16'h0BAD;
      do_reset();
      auto_mem = 1'b1; prev_strobe = 1'b0;
      for (int c = 0; c < 60 && grants.size() < 4; c++) begin
         @(negedge clk);
         if ((readM || writeM) && !prev_strobe)
            grants.push_back(writeM ? 2 : (address == 16'h0100 ? 0 : 1));
         prev_strobe = readM || writeM;
      end
      chk("c_count", grants.size(), 4);
      for (int g = 0; g < 4; g++)
         chk("c_order", (g < grants.size()) ? grants[g] : -1, (g % 2 == 0) ? 0 : 2);
      i_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (i_done) i_req = 1'b0;
         else if (!i_req && $urandom_range(0, 2) == 0) i_req = 1'b1;
         if (d_done) begin
            if (d_write_req) d_write_req = 1'b0; else d_read_req = 1'b0;
         end else begin
            if (!d_write_req && $urandom_range(0, 4) == 0) d_write_req = 1'b1;
            if (!d_read_req  && $urandom_range(0, 4) == 0) d_read_req  = 1'b1;
         end
         i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      end
      i_req = 1'b0; d_read_req = 1'b0; d_write_req = 1'b0;
      seen = 0;
      for (int c = 0; c < 50 && seen < 3; c++) begin
         @(negedge clk);
         if (!busy) seen++; else seen = 0;
      end
      chk("drain_idle", busy, 0);
      auto_mem = 1'b0; inputReady = 1'b0; ackOutput = 1'b0; tb_drv = 1'b0;
      @(negedge clk);

      // reset in the middle of a load
      d_read_req = 1'b1; d_addr = 16'h0ABC;
      do_reset();
      reset_n = 1'b0;
      @(negedge clk);
      chk("r_readM", readM, 1);
      reset_n = 1'b1;
      @(negedge clk);
      chk("r_readM_off", readM, 0); chk("r_idle", busy, 0); chk("r_no_done", d_done, 0);
      reset_n = 1'b0; d_read_req = 1'b0;
      inputReady = 1'b1; tb_drv = 1'b1; tb_dval = 16'h5555;
      @(negedge clk);
      chk("r_late_done", d_done, 0); chk("r_late_idle", busy, 0); chk("r_late_rdata", d_rdata, 0);
      inputReady = 1'b0; tb_drv = 1'b0;
      @(negedge clk);
      chk("r_late_done2", d_done, 0);

`ifdef MEM_ARB_TIMEOUT_EN
      // no response: abort after TMO cycles
      d_read_req = 1'b1; d_addr = 16'h0077;
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         chk("t_readM", readM, 1);
      end
      @(negedge clk);
      chk("t_done", d_done, 1); chk("t_rdata", d_rdata, 0);
      chk("t_err", timeout_err, 1); chk("t_readM_off", readM, 0);
      d_read_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("t_err_sticky", timeout_err, 1);
      // response exactly in the expiry cycle wins
      d_read_req = 1'b1;
      do_reset();
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         if (k == TMO - 1) begin inputReady = 1'b1; tb_drv = 1'b1; tb_dval = 16'hBEEF; end
      end
      @(negedge clk);
      chk("t2_done", d_done, 1); chk("t2_rdata", d_rdata, 16'hBEEF); chk("t2_err", timeout_err, 0);
      d_read_req = 1'b0; inputReady = 1'b0; tb_drv = 1'b0;
      @(negedge clk);
`endif

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
